// File: rtl/ocm_pkg.sv
// rtl/ocm_pkg.sv - shared clear-FSM state type and frame-buffer geometry for the on-chip memory
package ocm_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int FB_WIDTH   = 640;
  localparam int FB_LINES   = 240;
  localparam int OCM_DEPTH  = FB_WIDTH * FB_LINES;
  localparam int OCM_DATA_W = 16;

endpackage

// File: rtl/ocm_clear_fsm.sv
// rtl/ocm_clear_fsm.sv - clear engine that sweeps a fill value across the whole array
// Drives an internal write port that the top muxes ahead of user port A.
module ocm_clear_fsm
  import ocm_pkg::*;
#(
  parameter int DATA_W = OCM_DATA_W,
  parameter int DEPTH  = OCM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_value,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_en,
  output logic [IDX_W-1:0]  o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  clr_state_t        r_state;
  clr_state_t        w_next;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
      r_value <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CLR_IDLE && i_start) begin
        r_cnt   <= '0;
        r_value <= i_value;
      end else if (r_state == CLR_CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CLR_IDLE:  if (i_start) w_next = CLR_CLEAR;
      CLR_CLEAR: if (r_cnt == LAST_IDX) w_next = CLR_DONE;
      CLR_DONE:  w_next = CLR_IDLE;
      default:   w_next = CLR_IDLE;
    endcase
  end

  assign o_busy    = (r_state == CLR_CLEAR);
  assign o_done    = (r_state == CLR_DONE);
  assign o_wr_en   = (r_state == CLR_CLEAR);
  assign o_wr_addr = r_cnt;
  assign o_wr_data = r_value;

endmodule

// File: rtl/ocm_dual_port.sv
// rtl/ocm_dual_port.sv - true-dual-port frame-buffer memory with pipelined reads and clear engine
// Read-first on both ports; port A wins a same-address write collision.
module ocm_dual_port #(
  parameter int DATA_W = ocm_pkg::OCM_DATA_W,
  parameter int DEPTH  = ocm_pkg::OCM_DEPTH,
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic              MAIN_CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] OCM_ADDR_A,
  input  logic [ADDR_W-1:0] OCM_ADDR_B,
  input  logic [DATA_W-1:0] OCM_DATAIN_A,
  input  logic [DATA_W-1:0] OCM_DATAIN_B,
  input  logic              OCM_WE_A,
  input  logic              OCM_WE_B,
  input  logic              OCM_RE_A,
  input  logic              OCM_RE_B,
  output logic [DATA_W-1:0] OCM_DATAOUT_A,
  output logic [DATA_W-1:0] OCM_DATAOUT_B,
  output logic              OCM_VALID_A,
  output logic              OCM_VALID_B,
  input  logic              CLR_START,
  input  logic [DATA_W-1:0] CLR_VALUE,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  output logic              OCM_OOR
);
  import ocm_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clr_en;
  logic [IDX_W-1:0]  w_clr_addr;
  logic [DATA_W-1:0] w_clr_data;
  logic              w_oor_a, w_oor_b;
  logic              w_we_a, w_we_b;
  logic [IDX_W-1:0]  w_wa_addr;
  logic [DATA_W-1:0] w_wa_data;
  logic [IDX_W-1:0]  w_idx_a, w_idx_b;

  logic              r_v1_a, r_v1_b, r_v2_a, r_v2_b, r_oor;
  logic [DATA_W-1:0] r_d1_a, r_d1_b, r_d2_a, r_d2_b;

  ocm_clear_fsm #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_clear (
    .i_clk     (MAIN_CLK),
    .i_rst_n   (RESET_N),
    .i_start   (CLR_START),
    .i_value   (CLR_VALUE),
    .o_busy    (CLR_BUSY),
    .o_done    (CLR_DONE),
    .o_wr_en   (w_clr_en),
    .o_wr_addr (w_clr_addr),
    .o_wr_data (w_clr_data)
  );

  assign w_oor_a = {1'b0, OCM_ADDR_A} >= DEPTH_X;
  assign w_oor_b = {1'b0, OCM_ADDR_B} >= DEPTH_X;
  assign w_idx_a = OCM_ADDR_A[IDX_W-1:0];
  assign w_idx_b = OCM_ADDR_B[IDX_W-1:0];

  // The clear engine owns port A's write path while busy; user writes are dropped then.
  assign w_we_a    = w_clr_en | (OCM_WE_A & ~w_oor_a);
  assign w_wa_addr = w_clr_en ? w_clr_addr : w_idx_a;
  assign w_wa_data = w_clr_en ? w_clr_data : OCM_DATAIN_A;
  assign w_we_b    = OCM_WE_B & ~w_oor_b & ~w_clr_en;

  // Port A is written last so it overrides port B on an address collision.
  always_ff @(posedge MAIN_CLK) begin
    if (w_we_b) r_mem[w_idx_b] <= OCM_DATAIN_B;
    if (w_we_a) r_mem[w_wa_addr] <= w_wa_data;
  end

  always_ff @(posedge MAIN_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_v1_a <= 1'b0;
      r_v1_b <= 1'b0;
      r_v2_a <= 1'b0;
      r_v2_b <= 1'b0;
      r_d1_a <= '0;
      r_d1_b <= '0;
      r_d2_a <= '0;
      r_d2_b <= '0;
      r_oor  <= 1'b0;
    end else begin
      r_v1_a <= OCM_RE_A;
      r_v1_b <= OCM_RE_B;
      if (OCM_RE_A) r_d1_a <= w_oor_a ? '0 : r_mem[w_idx_a];
      if (OCM_RE_B) r_d1_b <= w_oor_b ? '0 : r_mem[w_idx_b];
      r_v2_a <= r_v1_a;
      r_v2_b <= r_v1_b;
      if (r_v1_a) r_d2_a <= r_d1_a;
      if (r_v1_b) r_d2_b <= r_d1_b;
      r_oor  <= ((OCM_RE_A | OCM_WE_A) & w_oor_a) | ((OCM_RE_B | OCM_WE_B) & w_oor_b);
    end
  end

  assign OCM_DATAOUT_A = (RD_LAT == 2) ? r_d2_a : r_d1_a;
  assign OCM_DATAOUT_B = (RD_LAT == 2) ? r_d2_b : r_d1_b;
  assign OCM_VALID_A   = (RD_LAT == 2) ? r_v2_a : r_v1_a;
  assign OCM_VALID_B   = (RD_LAT == 2) ? r_v2_b : r_v1_b;
  assign OCM_OOR       = r_oor;

endmodule

// File: tb/tb_ocm_dual_port.sv
// tb/tb_ocm_dual_port.sv - scoreboard bench driving an RD_LAT=1 and an RD_LAT=2 instance in lockstep
module tb_ocm_dual_port;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0, clr_value = '0;
  logic          we_a = 1'b0, we_b = 1'b0, re_a = 1'b0, re_b = 1'b0, clr_start = 1'b0;

  logic [DW-1:0] dout [2][2];
  logic          vld  [2][2];
  logic          busy [2];
  logic          done [2];
  logic          oor  [2];

  exp_t q [4][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_n, done_n, busy_at_done, oor_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ocm_dual_port #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .ADDR_W (AW),
      .RD_LAT (g + 1)
    ) u_dut (
      .MAIN_CLK      (clk),
      .RESET_N       (rst_n),
      .OCM_ADDR_A    (addr_a),
      .OCM_ADDR_B    (addr_b),
      .OCM_DATAIN_A  (din_a),
      .OCM_DATAIN_B  (din_b),
      .OCM_WE_A      (we_a),
      .OCM_WE_B      (we_b),
      .OCM_RE_A      (re_a),
      .OCM_RE_B      (re_b),
      .OCM_DATAOUT_A (dout[g][0]),
      .OCM_DATAOUT_B (dout[g][1]),
      .OCM_VALID_A   (vld[g][0]),
      .OCM_VALID_B   (vld[g][1]),
      .CLR_START     (clr_start),
      .CLR_VALUE     (clr_value),
      .CLR_BUSY      (busy[g]),
      .CLR_DONE      (done[g]),
      .OCM_OOR       (oor[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0; clr_start = 1'b0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 0) begin we_a = 1'b1; addr_a = a; din_a = d; end
    else           begin we_b = 1'b1; addr_b = a; din_b = d; end
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    exp_t e;
    if (port == 0) begin re_a = 1'b1; addr_a = a; end
    else           begin re_b = 1'b1; addr_b = a; end
    e.data = exp;
    e.cyc  = cyc;
    q[port].push_back(e);
    q[2 + port].push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (rst_n && vld[d][p]) begin
          if (q[d*2+p].size() == 0) begin
            chk($sformatf("unexpected_valid_lat%0d_p%0d", d + 1, p), 1, 0);
          end else begin
            e = q[d*2+p].pop_front();
            chk($sformatf("rdata_lat%0d_p%0d", d + 1, p), dout[d][p], e.data);
            chk($sformatf("latency_lat%0d_p%0d", d + 1, p), cyc - e.cyc, d + 1);
          end
        end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_dout_a", dout[d][0], 0);
      chk("rst_dout_b", dout[d][1], 0);
      chk("rst_valid_a", vld[d][0], 0);
      chk("rst_valid_b", vld[d][1], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_oor", oor[d], 0);
    end
    rst_n = 1'b1;
    step;

    wr(0, 5, 16'h1234); step;
    rd(1, 5, 16'h1234); step;
    wr(0, 3, 16'hAAAA); wr(1, 3, 16'h5555); step;
    rd(0, 3, 16'hAAAA); step;
    wr(0, 7, 16'h0001); step;
    rd(0, 7, 16'h0001); wr(0, 7, 16'h0002); step;
    rd(0, 7, 16'h0002); step;
    wr(0, 7, 16'h0003); rd(1, 7, 16'h0002); step;
    rd(1, 7, 16'h0003); rd(0, 5, 16'h1234); step;
    rd(0, 3, 16'hAAAA); step;
    repeat (3) step;

    clr_value = 16'hBEEF; clr_start = 1'b1; step;
    busy_n = 0; done_n = 0; busy_at_done = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy[0]) busy_n++;
      if (done[0]) begin done_n++; busy_at_done = busy_n; end
      if (busy[0] && busy_n == 5) begin clr_value = 16'h1111; clr_start = 1'b1; end
      if (busy[0] && busy_n == 10) begin wr(0, 2, 16'h7777); wr(1, 9, 16'h5151); end
      step;
    end
    chk("clear_busy_cycles", busy_n, 16);
    chk("clear_done_pulses", done_n, 1);
    chk("clear_done_after_busy", busy_at_done, 16);
    for (int i = 0; i < 16; i++) begin
      rd(0, AW'(i), 16'hBEEF); rd(1, AW'(15 - i), 16'hBEEF); step;
    end
    repeat (3) step;

    for (int i = 0; i < 8; i++) begin
      wr(0, AW'(i), DW'(16'h1000 + i)); wr(1, AW'(i + 8), DW'(16'h1008 + i)); step;
    end
    clr_value = 16'hBEEF; clr_start = 1'b1; step;
    repeat (5) step;
    rst_n = 1'b0;
    #1;
    chk("midclr_busy_lat1", busy[0], 0);
    chk("midclr_busy_lat2", busy[1], 0);
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst_n = 1'b1;
      step;
      if (done[0] || done[1]) done_n++;
      if (busy[0] || busy[1]) busy_n++;
    end
    chk("midclr_no_done", done_n, 0);
    chk("midclr_no_busy", busy_n, 0);
    for (int i = 0; i < 16; i++) begin
      rd(0, AW'(i), (i < 5) ? 16'hBEEF : DW'(16'h1000 + i)); step;
    end
    repeat (3) step;

    oor_n = 0;
    rd(0, 20, 16'h0000); step;
    chk("oor_rd_lat1", oor[0], 1);
    chk("oor_rd_lat2", oor[1], 1);
    for (int i = 0; i < 3; i++) begin step; if (oor[0]) oor_n++; end
    chk("oor_single_pulse", oor_n, 0);
    wr(1, 20, 16'hDEAD); step;
    chk("oor_wr", oor[0], 1);
    step;
    chk("oor_wr_clear", oor[0], 0);
    rd(0, 4, 16'hBEEF); rd(1, 15, 16'h100F); step;
    repeat (4) step;
    chk("hold_dout_lat1", dout[0][0], 16'hBEEF);
    chk("hold_dout_lat2", dout[1][0], 16'hBEEF);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_q%0d", i), q[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
